// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, field widths and the master state encoding.
package mdio_pkg;

    localparam int unsigned PhyW  = 5;
    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 16;

    localparam logic [1:0] StartBits = 2'b01;
    localparam logic [1:0] OpWr      = 2'b01;
    localparam logic [1:0] OpRd      = 2'b10;
    localparam logic [1:0] TaWr      = 2'b10;

    typedef enum logic [3:0] {
        StIdle,
        StPre,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StData,
        StEnd
    } mdio_state_e;

endpackage

// File: rtl/mdio_if.sv
// Command/response bus between a requester and the MDIO master.
interface mdio_if;
    import mdio_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rd;
    logic [PhyW-1:0]  cmd_phy;
    logic [RegW-1:0]  cmd_reg;
    logic [DataW-1:0] cmd_wdata;
    logic             rsp_valid;
    logic [DataW-1:0] rsp_rdata;
    logic             rsp_err;

    // Requester side.
    modport master (
        output cmd_valid, cmd_rd, cmd_phy, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // MDIO master side.
    modport slave (
        input  cmd_valid, cmd_rd, cmd_phy, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mdio_clkgen.sv
// MDC generator: one bit period is CLK_DIV clks, low for the first half.
// rise/fall flag the clk edges that will drive mdc 0->1 and 1->0.
module mdio_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int unsigned   PhW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PhW-1:0] RiseAt = PhW'(CLK_DIV / 2 - 1);
    localparam logic [PhW-1:0] LastPh = PhW'(CLK_DIV - 1);

    logic [PhW-1:0] ph_q;

    assign rise = run && !start && (ph_q == RiseAt);
    assign fall = run && !start && (ph_q == LastPh);

    // Phase counter restarts on frame start and parks at zero while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q <= '0;
            mdc  <= 1'b0;
        end else if (start || !run) begin
            ph_q <= '0;
            mdc  <= 1'b0;
        end else begin
            ph_q <= (ph_q == LastPh) ? '0 : ph_q + 1'b1;
            if (rise) begin
                mdc <= 1'b1;
            end else if (fall) begin
                mdc <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read or write frame per accepted command.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    mdio_if.slave cmd,
    output logic  busy,
    output logic  mdc,
    output logic  mdio_o,
    output logic  mdio_oe,
    input  logic  mdio_i
);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || PRE_LEN > 32) begin : g_bad_param
        $error("mdio_master: CLK_DIV must be even and >= 2, PRE_LEN <= 32");
    end

    mdio_state_e      state_q, nxt_state;
    logic [4:0]       cnt_q, nxt_cnt;
    logic             rd_q, ta_err_q, ready_q, busy_q, rv_q, err_q, o_q, oe_q;
    logic [PhyW-1:0]  phy_q;
    logic [RegW-1:0]  reg_q;
    logic [DataW-1:0] wd_q, sh_q, rdata_q;
    logic [1:0]       nxt_bit;
    logic             accept, rise, fall, last;

    // {oe, o} for a given frame position; undriven positions idle high.
    function automatic logic [1:0] frame_bit(mdio_state_e s, logic [4:0] c, logic rd,
                                             logic [PhyW-1:0] phy, logic [RegW-1:0] rg,
                                             logic [DataW-1:0] wd);
        logic [1:0] res;
        logic [1:0] op;
        op  = rd ? OpRd : OpWr;
        res = 2'b01;
        case (s)
            StPre:   res = 2'b11;
            StSt:    res = {1'b1, StartBits[~c[0]]};
            StOp:    res = {1'b1, op[~c[0]]};
            StPhyad: res = {1'b1, phy[3'd4 - c[2:0]]};
            StRegad: res = {1'b1, rg[3'd4 - c[2:0]]};
            StTa:    res = rd ? 2'b01 : {1'b1, TaWr[~c[0]]};
            StData:  res = rd ? 2'b01 : {1'b1, wd[4'd15 - c[3:0]]};
            default: res = 2'b01;
        endcase
        return res;
    endfunction

    assign accept = cmd.cmd_valid && ready_q;

    mdio_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk  (clk),
        .rst_n(rst_n),
        .start(accept),
        .run  (busy_q),
        .mdc  (mdc),
        .rise (rise),
        .fall (fall)
    );

    // Next frame position after the current bit, and the pin values it needs.
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q + 5'd1;
        case (state_q)
            StPre:           last = (cnt_q == 5'(PRE_LEN - 1));
            StSt, StOp, StTa: last = (cnt_q == 5'd1);
            StPhyad, StRegad: last = (cnt_q == 5'd4);
            StData:          last = (cnt_q == 5'd15);
            default:         last = 1'b1;
        endcase
        if (last) begin
            nxt_cnt = 5'd0;
            case (state_q)
                StPre:   nxt_state = StSt;
                StSt:    nxt_state = StOp;
                StOp:    nxt_state = StPhyad;
                StPhyad: nxt_state = StRegad;
                StRegad: nxt_state = StTa;
                StTa:    nxt_state = StData;
                StData:  nxt_state = StEnd;
                default: nxt_state = StIdle;
            endcase
        end
        nxt_bit = frame_bit(nxt_state, nxt_cnt, rd_q, phy_q, reg_q, wd_q);
    end

    // Frame sequencer: pins move on fall strobes, mdio_i is sampled on rise strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            phy_q    <= '0;
            reg_q    <= '0;
            wd_q     <= '0;
            sh_q     <= '0;
            ta_err_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            o_q      <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (accept) begin
                state_q  <= (PRE_LEN > 0) ? StPre : StSt;
                cnt_q    <= '0;
                rd_q     <= cmd.cmd_rd;
                phy_q    <= cmd.cmd_phy;
                reg_q    <= cmd.cmd_reg;
                wd_q     <= cmd.cmd_wdata;
                sh_q     <= '0;
                ta_err_q <= 1'b0;
                ready_q  <= 1'b0;
                busy_q   <= 1'b1;
                o_q      <= (PRE_LEN > 0);
                oe_q     <= 1'b1;
            end else if (busy_q) begin
                if (rise && rd_q) begin
                    if (state_q == StTa && cnt_q[0]) begin
                        ta_err_q <= mdio_i;
                    end
                    if (state_q == StData) begin
                        sh_q <= {sh_q[DataW-2:0], mdio_i};
                    end
                end
                if (fall) begin
                    state_q       <= nxt_state;
                    cnt_q         <= nxt_cnt;
                    {oe_q, o_q}   <= nxt_bit;
                    if (state_q == StEnd) begin
                        rv_q    <= 1'b1;
                        rdata_q <= rd_q ? sh_q : '0;
                        err_q   <= rd_q & ta_err_q;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            end
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rv_q;
    assign cmd.rsp_rdata = rdata_q;
    assign cmd.rsp_err   = err_q;
    assign busy          = busy_q;
    assign mdio_o        = o_q;
    assign mdio_oe       = oe_q;

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CLK_DIV, 4: clk cycles per MDC period; even, at least 2.
- PRE_LEN, 32: preamble bits (0..32); 0 means preamble suppressed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk in 1: system clock.
- rst_n in 1: synchronous active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accept.
- cmd_rd in 1: 1 = read, 0 = write.
- cmd_phy in 5: PHY address.
- cmd_reg in 5: register address.
- cmd_wdata in 16: write data.
- rsp_valid out 1: one-clk completion pulse.
- rsp_rdata out 16: read data; 0 after a write.
- rsp_err out 1: read turnaround error.
- busy out 1: frame in progress.
- mdc out 1: management clock.
- mdio_o out 1: MDIO drive value.
- mdio_oe out 1: MDIO drive enable.
- mdio_i in 1: MDIO pad input.

Function
REQ-004 A command SHALL be accepted on the clk edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 only in IDLE.
- All command fields are latched at acceptance; later changes are ignored.
REQ-005 States SHALL be IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, END.
- PRE is skipped when PRE_LEN = 0.
- A bit counter sequences each state.
REQ-006 Each frame bit SHALL last CLK_DIV clks: mdc is 0 for the first CLK_DIV/2 clks and 1 for the rest.
- mdc is held at 0 in IDLE.
REQ-007 mdio_o and mdio_oe SHALL change only on the acceptance edge or on edges that drive mdc from 1 to 0.
- mdio_i SHALL be sampled on edges that drive mdc from 0 to 1.
REQ-008 Write frame bit order:
- PRE_LEN ones.
- ST = 01, OP = 01.
- PHYAD, then REGAD, each MSB first.
- TA = 10, driven.
- 16 data bits, MSB first.
- mdio_oe = 1 throughout.
REQ-009 Read frame bit order:
- OP = 10.
- mdio_oe drops to 0 at the start of TA and stays 0 through DATA.
- The second TA sample is checked; 16 data bits are sampled MSB first into rsp_rdata.
REQ-010 rsp_err SHALL be set if the second TA sample is 1. rsp_err is 0 for writes.
REQ-011 END SHALL be one bit period with mdio_oe = 0.
- On the edge that completes END: rsp_valid pulses, rsp_rdata/rsp_err update, the state returns to IDLE, and cmd_ready rises.
REQ-012 Latency SHALL be exactly (PRE_LEN+33)*CLK_DIV clks from the acceptance edge to rsp_valid.
REQ-013 busy SHALL be 1 from the acceptance edge until the rsp_valid edge, exclusive of the rsp_valid cycle.
REQ-014 A command presented in the rsp_valid cycle SHALL be accepted on the next edge.
- Back-to-back frames are separated only by END.
REQ-015 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.

Reset
REQ-016 While rst_n = 0 at a clk edge, the block SHALL set:
- state = IDLE.
- mdc = 0, mdio_o = 1, mdio_oe = 0.
- cmd_ready = 1 after release.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
- Counters = 0.
REQ-017 A reset in mid-frame SHALL abort the frame with no rsp_valid.

Structure
REQ-018 Package mdio_pkg SHALL hold:
- The state enum.
- ST/OP constants (ST 01, OP_WR 01, OP_RD 10, TA_WR 10).
- Field widths (5, 5, 16).
REQ-019 Sub-module mdio_clkgen SHALL generate mdc plus rise/fall strobes from a CLK_DIV phase counter.
- It is restarted by the frame-start strobe.
REQ-020 Elaboration SHALL fail if CLK_DIV is odd or less than 2, or if PRE_LEN > 32.

Verification
REQ-021 Write, CLK_DIV=4, PRE_LEN=32, phy 0x10, reg 0x00, data 0x8140:
- mdio_o sampled at mdc rise = 32x1, 01, 01, 10000, 00000, 10, 1000000101000000.
- mdio_oe = 1 throughout; rsp_valid at clk 260; rsp_err = 0.
REQ-022 Read, phy 0x10, reg 0x14; PHY model drives 0 on TA2, then 0x0070:
- rsp_rdata = 0x0070, rsp_err = 0.
- mdio_oe falls at the first TA bit.
REQ-023 Read with mdio_i tied to 1 (no PHY):
- rsp_rdata = 0xFFFF, rsp_err = 1.
REQ-024 cmd_valid held high during a frame, with fields changing mid-frame:
- The first frame is unaffected.
- The second command is accepted in the rsp_valid cycle.
REQ-025 rst_n low during PHYAD:
- Next edge gives mdc = 0, mdio_oe = 0, busy = 0, with no rsp_valid.
- A following write completes normally.
REQ-026 PRE_LEN=0 instance:
- The frame starts with ST.
- rsp_valid arrives at 33*CLK_DIV clks.
